// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready flow control, an optional skid entry,
// flush-to-bubble and a saturating back-pressure counter.
module pipe_stage_buf #(
  parameter int              DATA_W   = 64,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] PC_RESET = 32'h0000_3000,
  parameter int              SKID     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [4:0]        in_wreg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_pc8,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_wreg,
  output logic [15:0]       stall_cnt
);

  // Handshake: a word moves when valid && ready on the same rising edge; valid never
  // waits on ready, and flush wins over any transfer in its cycle.
  logic              head_valid, skid_valid, rdy_q;
  logic [31:0]       head_instr, skid_instr;
  logic [PC_W-1:0]   head_pc, head_pc8, skid_pc;
  logic [DATA_W-1:0] head_data, skid_data;
  logic [4:0]        head_wreg, skid_wreg;
  logic [15:0]       stall_q;

  logic accept, pop;
  logic head_valid_n, skid_valid_n;
  logic head_load_in, head_load_skid, skid_load;

  // rdy_q is 0 in reset and 1 from the first edge after it, for both builds.
  assign in_ready = rdy_q && ((SKID != 0) || !head_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign pop      = head_valid && out_ready;

  always_comb begin
    head_valid_n   = head_valid;
    skid_valid_n   = skid_valid;
    head_load_in   = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (accept && pop) begin
      if (skid_valid) begin
        head_load_skid = 1'b1;
        skid_load      = 1'b1;
      end else begin
        head_load_in = 1'b1;
      end
    end else if (accept) begin
      if (!head_valid) begin
        head_load_in = 1'b1;
        head_valid_n = 1'b1;
      end else begin
        skid_load    = 1'b1;
        skid_valid_n = 1'b1;
      end
    end else if (pop) begin
      if (skid_valid) begin
        head_load_skid = 1'b1;
        skid_valid_n   = 1'b0;
      end else begin
        head_valid_n = 1'b0;
      end
    end
    if (SKID == 0) skid_valid_n = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      rdy_q      <= 1'b0;
      head_instr <= '0;
      head_pc    <= PC_RESET;
      head_pc8   <= PC_RESET;
      head_data  <= '0;
      head_wreg  <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_data  <= '0;
      skid_wreg  <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      rdy_q      <= 1'b1;
      head_pc    <= PC_RESET;
      head_pc8   <= PC_RESET;
    end else begin
      head_valid <= head_valid_n;
      skid_valid <= skid_valid_n;
      rdy_q      <= !skid_valid_n;
      if (head_load_in) begin
        head_instr <= in_instr;
        head_pc    <= in_pc;
        head_pc8   <= in_pc + PC_W'(8);
        head_data  <= in_data;
        head_wreg  <= in_wreg;
      end else if (head_load_skid) begin
        head_instr <= skid_instr;
        head_pc    <= skid_pc;
        head_pc8   <= skid_pc + PC_W'(8);
        head_data  <= skid_data;
        head_wreg  <= skid_wreg;
      end
      if (skid_load) begin
        skid_instr <= in_instr;
        skid_pc    <= in_pc;
        skid_data  <= in_data;
        skid_wreg  <= in_wreg;
      end
    end
  end

  // Performance counter survives flush; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (head_valid && !out_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign out_valid = head_valid;
  assign out_instr = head_valid ? head_instr : 32'd0;
  assign out_wreg  = head_valid ? head_wreg : 5'd0;
  assign out_pc    = head_pc;
  assign out_pc8   = head_pc8;
  assign out_data  = head_data;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a SKID=1 and a SKID=0 instance driven by directed vectors,
// with accepted words queued and compared as they leave each stage.
module tb_pipe_stage_buf;
  localparam int DW = 64;
  localparam int PW = 32;
  localparam int W  = 32 + PW + PW + DW + 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0]   in_instr = '0, out_instr;
  logic [PW-1:0] in_pc = '0, out_pc, out_pc8;
  logic [DW-1:0] in_data = '0, out_data;
  logic [4:0]    in_wreg = '0, out_wreg;
  logic [15:0]   stall_cnt;

  logic          z_in_valid = 1'b0, z_in_ready, z_flush = 1'b0, z_out_valid, z_out_ready = 1'b0;
  logic [31:0]   z_in_instr = '0, z_out_instr;
  logic [PW-1:0] z_in_pc = '0, z_out_pc, z_out_pc8;
  logic [DW-1:0] z_in_data = '0, z_out_data;
  logic [4:0]    z_in_wreg = '0, z_out_wreg;
  logic [15:0]   z_stall_cnt;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] z_q[$];
  logic [W-1:0] m_e, z_e;

  pipe_stage_buf #(.DATA_W(DW), .PC_W(PW), .PC_RESET(32'h0000_3000), .SKID(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data), .in_wreg(in_wreg),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc8(out_pc8), .out_data(out_data),
    .out_wreg(out_wreg), .stall_cnt(stall_cnt));

  pipe_stage_buf #(.DATA_W(DW), .PC_W(PW), .PC_RESET(32'h0000_3000), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_instr(z_in_instr), .in_pc(z_in_pc), .in_data(z_in_data), .in_wreg(z_in_wreg),
    .flush(z_flush), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_instr(z_out_instr), .out_pc(z_out_pc), .out_pc8(z_out_pc8), .out_data(z_out_data),
    .out_wreg(z_out_wreg), .stall_cnt(z_stall_cnt));

  function automatic logic [W-1:0] make_item(logic [31:0] i, logic [PW-1:0] p,
                                             logic [DW-1:0] d, logic [4:0] w);
    logic [PW-1:0] p8;
    p8 = p + 32'd8;
    return {i, p, p8, d, w};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] i, logic [PW-1:0] p);
    in_valid = v;
    in_instr = i;
    in_pc    = p;
    in_data  = {i, ~i};
    in_wreg  = i[4:0];
  endtask

  task automatic zdrive(logic v, logic [31:0] i, logic [PW-1:0] p);
    z_in_valid = v;
    z_in_instr = i;
    z_in_pc    = p;
    z_in_data  = {~i, i};
    z_in_wreg  = i[4:0];
  endtask

  // Scoreboard for the SKID=1 instance: pop-and-compare first, then record accepts.
  always @(negedge clk) begin
    if (!reset || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL skid1_extra_word: got %h expected none", {out_instr, out_pc, out_pc8, out_data, out_wreg});
        end else begin
          m_e = exp_q.pop_front();
          if ({out_instr, out_pc, out_pc8, out_data, out_wreg} !== m_e) begin
            failures++;
            $display("FAIL skid1_word: got %h expected %h", {out_instr, out_pc, out_pc8, out_data, out_wreg}, m_e);
          end
        end
      end
      if (!out_valid) begin
        checks++;
        if (out_instr !== 32'd0 || out_wreg !== 5'd0) begin
          failures++;
          $display("FAIL skid1_bubble_nop: got instr %0h wreg %0h expected 0 0", out_instr, out_wreg);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(make_item(in_instr, in_pc, in_data, in_wreg));
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      z_q.delete();
    end else begin
      if (z_out_valid && z_out_ready) begin
        checks++;
        if (z_q.size() == 0) begin
          failures++;
          $display("FAIL skid0_extra_word: got %h expected none", {z_out_instr, z_out_pc, z_out_pc8, z_out_data, z_out_wreg});
        end else begin
          z_e = z_q.pop_front();
          if ({z_out_instr, z_out_pc, z_out_pc8, z_out_data, z_out_wreg} !== z_e) begin
            failures++;
            $display("FAIL skid0_word: got %h expected %h", {z_out_instr, z_out_pc, z_out_pc8, z_out_data, z_out_wreg}, z_e);
          end
        end
      end
      if (z_in_valid && z_in_ready) z_q.push_back(make_item(z_in_instr, z_in_pc, z_in_data, z_in_wreg));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 32'h3000);
    check("rst_out_pc8", out_pc8, 32'h3000);
    check("rst_out_data", out_data, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h11 + k, 32'h3000 + 4 * k);
      tick();
      check("stream_no_bubble", out_valid, 1);
      check("stream_in_ready", in_ready, 1);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("stream_drained", exp_q.size(), 0);
    check("stream_idle", out_valid, 0);

    // Skid fill and drain
    drive(1'b1, 32'h21, 32'h3100);
    tick();
    drive(1'b1, 32'h22, 32'h3104);
    tick();
    drive(1'b1, 32'h23, 32'h3108);
    out_ready = 1'b0;
    tick();
    check("skid_in_ready_fall", in_ready, 0);
    check("skid_head_held", out_instr, 32'h22);
    drive(1'b1, 32'h24, 32'h310C);
    tick(4);
    check("skid_stall_cnt5", stall_cnt, 5);
    check("skid_in_ready_low", in_ready, 0);
    check("skid_head_still", out_instr, 32'h22);
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("skid_second_word", out_instr, 32'h23);
    check("skid_in_ready_back", in_ready, 1);
    tick();
    check("skid_drain_empty", out_valid, 0);
    check("skid_drain_queue", exp_q.size(), 0);
    check("skid_stall_kept", stall_cnt, 5);

    // Flush with two entries held, same cycle as a pop
    out_ready = 1'b0;
    drive(1'b1, 32'h31, 32'h3200);
    tick();
    drive(1'b1, 32'h32, 32'h3204);
    tick();
    check("flush_full_in_ready", in_ready, 0);
    drive(1'b1, 32'h33, 32'h3208);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_out_instr", out_instr, 0);
    check("flush_out_wreg", out_wreg, 0);
    check("flush_out_pc", out_pc, 32'h3000);
    check("flush_out_pc8", out_pc8, 32'h3000);
    check("flush_in_ready", in_ready, 1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("flush_no_input", out_valid, 0);
    check("flush_stall_kept", stall_cnt, 6);

    // Flush beats a same-cycle accept and pop
    drive(1'b1, 32'h41, 32'h3300);
    tick();
    drive(1'b1, 32'h42, 32'h3304);
    check("flush2_ready_before", in_ready, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush2_out_valid", out_valid, 0);
    check("flush2_out_pc", out_pc, 32'h3000);
    tick();
    check("flush2_dropped", out_valid, 0);

    // PC + 8 wrap
    drive(1'b1, 32'h51, 32'hFFFF_FFFC);
    tick();
    check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_out_pc8", out_pc8, 32'h0000_0004);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("wrap_drained", exp_q.size(), 0);

    // Reset mid-transfer with two entries held
    out_ready = 1'b0;
    drive(1'b1, 32'h61, 32'h3400);
    tick();
    drive(1'b1, 32'h62, 32'h3404);
    tick();
    check("mid_stall_cnt", stall_cnt, 7);
    check("mid_held", out_valid, 1);
    reset = 1'b0;
    drive(1'b1, 32'h63, 32'h3408);
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_instr", out_instr, 0);
    check("mid_rst_out_wreg", out_wreg, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_pc", out_pc, 32'h3000);
    check("mid_rst_out_pc8", out_pc8, 32'h3000);
    check("mid_rst_stall_cnt", stall_cnt, 0);
    check("mid_rst_in_ready", in_ready, 0);
    tick(2);
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("mid_release_in_ready", in_ready, 1);
    check("mid_release_empty", out_valid, 0);

    // Stall counter saturation
    drive(1'b1, 32'h71, 32'h3500);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick(70000);
    check("sat_stall_cnt", stall_cnt, 16'hFFFF);
    tick(3);
    check("sat_stall_hold", stall_cnt, 16'hFFFF);
    check("sat_head_held", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("sat_drained", exp_q.size(), 0);

    // SKID=0 build: streaming, combinational ready, same-cycle accept and pop
    z_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      zdrive(1'b1, 32'h91 + k, 32'h3600 + 4 * k);
      tick();
      check("z_stream_valid", z_out_valid, 1);
    end
    zdrive(1'b0, 32'h0, 32'h0);
    tick();
    check("z_stream_drained", z_q.size(), 0);
    z_out_ready = 1'b0;
    zdrive(1'b1, 32'h81, 32'h3700);
    tick();
    check("z_ready_low_full", z_in_ready, 0);
    zdrive(1'b1, 32'h82, 32'h3704);
    tick();
    check("z_head_not_overwritten", z_out_instr, 32'h81);
    z_out_ready = 1'b1;
    #1;
    check("z_ready_comb_rise", z_in_ready, 1);
    tick();
    check("z_accept_pop_valid", z_out_valid, 1);
    check("z_accept_pop_instr", z_out_instr, 32'h82);
    z_out_ready = 1'b0;
    #1;
    check("z_ready_comb_fall", z_in_ready, 0);
    z_out_ready = 1'b1;
    zdrive(1'b0, 32'h0, 32'h0);
    tick();
    check("z_drained", z_q.size(), 0);
    check("z_empty", z_out_valid, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register: the successor of the fixed EX/MEM latch. It carries instruction, PC, payload and destination-register fields between any two stages of the pipelined CPU. It adds valid/ready flow control, an optional skid entry so upstream `in_ready` is registered, a flush that turns the stage into a bubble, and a saturating stall counter for performance monitoring. Drop-in candidate for the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.

## Interface

**Parameters**

- `DATA_W`, default 64: payload width (for example ALU result plus store data).
- `PC_W`, default 32: PC width.
- `PC_RESET`, default 32'h0000_3000: reset and bubble value of `out_pc` and `out_pc8`.
- `SKID`, default 1: 1 gives a 2-entry skid buffer with registered `in_ready`; 0 gives a single entry with pass-through ready.

**Ports**

- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream has a valid instruction.
- `in_ready` out 1: stage can accept this cycle.
- `in_instr` in 32: instruction word.
- `in_pc` in PC_W: PC of the instruction.
- `in_data` in DATA_W: payload.
- `in_wreg` in 5: destination register, 0 = none.
- `flush` in 1: discard all held entries (branch or exception).
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: downstream accepts the head entry.
- `out_instr` out 32: head instruction, 0 when invalid.
- `out_pc` out PC_W: head PC.
- `out_pc8` out PC_W: head PC + 8, modulo 2^PC_W.
- `out_data` out DATA_W: head payload.
- `out_wreg` out 5: head destination, 0 when invalid.
- `stall_cnt` out 16: saturating count of back-pressured cycles.

## Operation

- **Accept / pop.** Accept when `in_valid && in_ready`. Pop when `out_valid && out_ready`.
- **SKID=1 storage.** State is a head entry plus a skid entry; the skid entry is used only when the head is full.
  - Accept with no pop, head empty: the input goes to the head.
  - Accept with no pop, head full: the input goes to the skid entry.
  - Pop with no accept: skid moves to head, or the head empties.
  - Pop and accept together, skid empty: the input replaces the head.
  - Pop and accept together, skid full: skid moves to head and the input moves into skid. This cannot occur, because `in_ready` = 0 whenever skid is full.
  - `in_ready` is a register equal to !skid_full as of the next cycle.
- **SKID=0.**
  - `in_ready = !out_valid || out_ready`, combinational.
  - On accept, the head loads the input.
  - On pop with no accept, the head empties.
- **Order.** Entries are never reordered or duplicated. Occupancy is 0..2 (SKID=1) or 0..1 (SKID=0).
- **Invalid entries.**
  - `out_instr` = 0 and `out_wreg` = 0, so a bubble is a nop with no register write.
  - `out_pc`, `out_pc8` and `out_data` hold their last values.
- **`out_pc8`.** Computed from the stored PC. It wraps modulo 2^PC_W; for example, all-ones + 8 = 7.
- **Flush.**
  - At the edge, all entries are invalidated, `out_instr` and `out_wreg` go to 0, and `out_pc`/`out_pc8` go to PC_RESET.
  - Flush has priority over a same-cycle accept and pop. The input is dropped even though `in_ready` may have been 1.
  - After a flush, `in_ready` = 1 in the next cycle.
- **`stall_cnt`.** Increments each cycle `out_valid && !out_ready`, saturates at 16'hFFFF, is unaffected by flush, and is cleared only by reset.

## Timing

- **Reset values.** While `reset` = 0, asynchronously: all valids 0, `out_instr` = 0, `out_data` = 0, `out_wreg` = 0, `out_pc` = `out_pc8` = PC_RESET, `stall_cnt` = 0. `in_ready` is 0 during reset and 1 in the first cycle after deassertion.
- **Reset mid-transfer.** Assertion at any point discards the in-flight entries with no partial update.
- **Latency.** 1 cycle: data accepted at edge N appears on the outputs after edge N and is valid in cycle N+1.
- **Throughput.** 1 instruction per cycle when `out_ready` is held at 1, for both SKID settings.
- **SKID=1 back-pressure.** When `out_ready` drops, at most one further instruction is accepted. `in_ready` falls in the cycle after the skid entry fills.
- **Output stability.** Outputs are registered and do not depend combinationally on `out_ready` or `flush`. The exception is `in_ready` with SKID=0.

## Test plan

- **Reset.** Assert `reset` = 0 mid-stream with 2 entries held → `out_valid` = 0, `out_pc` = 32'h3000, `out_pc8` = 32'h3000, `in_instr` not visible, `stall_cnt` = 0, `in_ready` = 1 after release.
- **Streaming.** Hold `out_ready` = 1 and push instr 0x11..0x18 on consecutive cycles with PC 0x3000+4k → the same sequence appears one cycle later, `out_pc8` = PC+8, no bubbles.
- **Skid (SKID=1).**
  - Drop `out_ready` while streaming → exactly one extra word is accepted and `in_ready` = 0 the next cycle.
  - Hold `out_ready` low for 5 cycles → `stall_cnt` = 5.
  - Raise `out_ready` → the two held words drain in order, with no loss or duplication.
- **Flush priority.** Flush in the same cycle as accept and pop, with 2 entries held → `out_valid` = 0, `out_instr` = 0, `out_wreg` = 0, `out_pc` = 0x3000. The input word never appears.
- **Saturation and wrap.**
  - Hold back-pressure for 70000 cycles → `stall_cnt` = 16'hFFFF and stays there.
  - Push PC 32'hFFFF_FFFC → `out_pc8` = 32'h0000_0004.
- **SKID=0 build.** Hold `out_ready` = 0 with the head full → `in_ready` = 0 combinationally in the same cycle. Raise `out_ready` → accept and pop occur in the same cycle.
